// File: rtl/csu_pkg.sv
// Shared types and constants for the channel signature unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   csu_state_e      : run-control FSM states
//   CSU_DEFAULT_POLY : default MISR feedback polynomial (CRC-32 style)
package csu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } csu_state_e;

    localparam logic [31:0] CSU_DEFAULT_POLY = 32'h04C11DB7;

endpackage

// File: rtl/csu_misr_step.sv
// One MISR step: shift the signature left, fold in POLY on carry-out, XOR the merged word.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is registered.
//   sig_in  [WIDTH] : current signature
//   merged  [WIDTH] : XOR of all channel words for this beat
//   sig_out [WIDTH] : next signature
module csu_misr_step #(
    parameter int                WIDTH = 32,
    parameter logic [WIDTH-1:0]  POLY  = '1
) (
    input  logic [WIDTH-1:0] sig_in,
    input  logic [WIDTH-1:0] merged,
    output logic [WIDTH-1:0] sig_out
);

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = {sig_in[WIDTH-2:0], 1'b0};
        // The bit shifted out of the MSB selects the polynomial feedback.
        if (sig_in[WIDTH-1]) begin
            shifted = shifted ^ POLY;
        end
        sig_out = shifted ^ merged;
    end

endmodule

// File: rtl/channel_signature_unit.sv
// XOR-merges per-channel result words and compresses SAMPLES beats (after FILL warm-up beats) into a MISR signature.
// Latency: sig updates on the edge accepting a beat; done/busy/match registered, visible the cycle after the final beat.
// Backpressure: none; the unit is always ready, in_valid simply qualifies each beat and idle cycles hold state.
// Ports:
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   start          : one-cycle run request, honoured only in IDLE or DONE
//   in_valid, d_in : beat qualifier and CHANNEL packed words (channel k at [k*WIDTH +: WIDTH])
//   golden         : expected signature, used only when CSU_GOLDEN_CMP_EN is defined
//   sig, busy, done, match : signature, FILL/RUN indicator, DONE indicator, registered golden compare
// Build option: define CSU_GOLDEN_CMP_EN to build the golden comparator; otherwise match is tied low.
module channel_signature_unit
    import csu_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               CHANNEL = 3,
    parameter int               SAMPLES = 16,
    parameter int               FILL    = 3,
    parameter logic [WIDTH-1:0] POLY    = WIDTH'(CSU_DEFAULT_POLY),
    parameter logic [WIDTH-1:0] SEED    = '1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [CHANNEL*WIDTH-1:0]   d_in,
    input  logic [WIDTH-1:0]           golden,
    output logic [WIDTH-1:0]           sig,
    output logic                       busy,
    output logic                       done,
    output logic                       match
);

    // One counter serves both phases, so it is sized for the longer one.
    localparam int CNT_MAX = (FILL > SAMPLES) ? FILL : SAMPLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    csu_state_e       state_d, state_q;
    logic [WIDTH-1:0] sig_d, sig_q;
    logic [CW-1:0]    cnt_d, cnt_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;

    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] sig_step;
    logic [CW-1:0]    cnt_inc;

    always_comb begin
        merged = '0;
        for (int k = 0; k < CHANNEL; k++) begin
            merged = merged ^ d_in[k*WIDTH +: WIDTH];
        end
    end

    csu_misr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr_step (
        .sig_in  (sig_q),
        .merged  (merged),
        .sig_out (sig_step)
    );

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sig_d   = SEED;
                    cnt_d   = '0;
                    state_d = (FILL == 0) ? ST_RUN : ST_FILL;
                end
            end
            ST_FILL: begin
                // Warm-up beats are counted but their data is discarded.
                if (in_valid) begin
                    if (cnt_inc == CW'(FILL)) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    sig_d = sig_step;
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(SAMPLES)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Status outputs are registered copies of the next state.
        busy_d = (state_d == ST_FILL) || (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sig  = sig_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef CSU_GOLDEN_CMP_EN
    logic match_d, match_q;

    // Compare against the signature being registered so match lines up with done.
    assign match_d = (state_d == ST_DONE) && (sig_d == golden);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match = match_q;
`else
    logic unused_golden;
    assign unused_golden = ^golden;
    assign match         = 1'b0;
`endif

endmodule

// File: tb/tb_channel_signature_unit.sv
// Self-checking bench for channel_signature_unit: directed scenarios on small instances plus randomized runs.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_channel_signature_unit;

    localparam int         W      = 8;
    localparam int         CH     = 3;
    localparam logic [7:0] P      = 8'h1D;
    localparam logic [7:0] SEED_R = 8'hA5;
    localparam int         FILL_R = 2;
    localparam int         SAMP_R = 5;
`ifdef CSU_GOLDEN_CMP_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [CH*W-1:0]   d_in = '0;
    logic [W-1:0]      golden = '0;
    logic [4:0][W-1:0] sig_o;
    logic [4:0]        busy_o, done_o, match_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // u0: SEED 0, FILL 0, SAMPLES 1
    channel_signature_unit #(.WIDTH(W), .CHANNEL(CH), .SAMPLES(1), .FILL(0), .POLY(P), .SEED(8'h00)) u0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .d_in(d_in), .golden(golden),
        .sig(sig_o[0]), .busy(busy_o[0]), .done(done_o[0]), .match(match_o[0]));
    // u1: SEED 0, FILL 0, SAMPLES 2
    channel_signature_unit #(.WIDTH(W), .CHANNEL(CH), .SAMPLES(2), .FILL(0), .POLY(P), .SEED(8'h00)) u1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .d_in(d_in), .golden(golden),
        .sig(sig_o[1]), .busy(busy_o[1]), .done(done_o[1]), .match(match_o[1]));
    // u2: SEED 80, FILL 0, SAMPLES 1
    channel_signature_unit #(.WIDTH(W), .CHANNEL(CH), .SAMPLES(1), .FILL(0), .POLY(P), .SEED(8'h80)) u2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .d_in(d_in), .golden(golden),
        .sig(sig_o[2]), .busy(busy_o[2]), .done(done_o[2]), .match(match_o[2]));
    // u3: default SEED (all ones), FILL 3, SAMPLES 1
    channel_signature_unit #(.WIDTH(W), .CHANNEL(CH), .SAMPLES(1), .FILL(3), .POLY(P)) u3 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .d_in(d_in), .golden(golden),
        .sig(sig_o[3]), .busy(busy_o[3]), .done(done_o[3]), .match(match_o[3]));
    // ur: randomized-run instance
    channel_signature_unit #(.WIDTH(W), .CHANNEL(CH), .SAMPLES(SAMP_R), .FILL(FILL_R), .POLY(P), .SEED(SEED_R)) ur (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .d_in(d_in), .golden(golden),
        .sig(sig_o[4]), .busy(busy_o[4]), .done(done_o[4]), .match(match_o[4]));

    // Reference: multiply the signature polynomial by x modulo x^8+POLY, then add the merged word.
    function automatic logic [7:0] misr_ref(input logic [7:0] s, input logic [7:0] m);
        logic [8:0] w;
        w = {s, 1'b0};
        if (w[8]) w = w ^ {1'b1, P};
        return w[7:0] ^ m;
    endfunction

    function automatic logic [7:0] merge_ref(input logic [CH*W-1:0] d);
        logic [7:0] acc;
        acc = 8'h00;
        for (int k = 0; k < CH; k++) acc = acc ^ d[k*W +: W];
        return acc;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({sig_o[i], busy_o[i], done_o[i], match_o[i]} !== 11'h0) begin
                failures++;
                $display("FAIL reset_values inst%0d: got sig=%h busy=%b done=%b match=%b want all 0",
                         i, sig_o[i], busy_o[i], done_o[i], match_o[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_samples();
        apply_reset();
        golden = 8'h0E;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({sig_o[0], busy_o[0], done_o[0]} !== {8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL start_seed u0: got sig=%h busy=%b done=%b want 00 1 0", sig_o[0], busy_o[0], done_o[0]);
        end
        in_valid = 1'b1;
        d_in = {8'h04, 8'h02, 8'h01};
        step();
        checks++;
        if ({sig_o[0], busy_o[0], done_o[0]} !== {8'h07, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL one_sample u0: got sig=%h busy=%b done=%b want 07 0 1", sig_o[0], busy_o[0], done_o[0]);
        end
        checks++;
        if ({sig_o[1], busy_o[1], done_o[1]} !== {8'h07, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL two_sample_first u1: got sig=%h busy=%b done=%b want 07 1 0", sig_o[1], busy_o[1], done_o[1]);
        end
        d_in = {8'h33, 8'h22, 8'h11};
        step();
        in_valid = 1'b0;
        checks++;
        if ({sig_o[1], busy_o[1], done_o[1], match_o[1]} !== {8'h0E, 1'b0, 1'b1, CMP}) begin
            failures++;
            $display("FAIL two_sample_done u1: got sig=%h busy=%b done=%b match=%b want 0e 0 1 %b",
                     sig_o[1], busy_o[1], done_o[1], match_o[1], CMP);
        end
        checks++;
        if ({sig_o[0], done_o[0], match_o[0]} !== {8'h07, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL done_frozen u0: got sig=%h done=%b match=%b want 07 1 0", sig_o[0], done_o[0], match_o[0]);
        end
        golden = 8'h0F;
        step();
        checks++;
        if ({sig_o[1], done_o[1], match_o[1]} !== {8'h0E, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL golden_mismatch u1: got sig=%h done=%b match=%b want 0e 1 0", sig_o[1], done_o[1], match_o[1]);
        end
    endtask

    task automatic test_feedback();
        apply_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (sig_o[2] !== 8'h80) begin
            failures++;
            $display("FAIL feedback_seed u2: got %h want 80", sig_o[2]);
        end
        in_valid = 1'b1;
        d_in = '0;
        step();
        in_valid = 1'b0;
        checks++;
        if ({sig_o[2], done_o[2]} !== {8'h1D, 1'b1}) begin
            failures++;
            $display("FAIL feedback_step u2: got sig=%h done=%b want 1d 1", sig_o[2], done_o[2]);
        end
    endtask

    task automatic test_fill();
        logic [7:0] exp_sig;
        int vb;
        apply_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_sig = 8'hFF;
        vb = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            d_in = CH*W'($urandom);
            step();
            if (in_valid) begin
                vb++;
                if (vb == 4) exp_sig = misr_ref(exp_sig, merge_ref(d_in));
            end
            checks++;
            if ({sig_o[3], busy_o[3], done_o[3]} !== {exp_sig, vb < 4, vb >= 4}) begin
                failures++;
                $display("FAIL fill_beat%0d u3: got sig=%h busy=%b done=%b want %h %b %b",
                         i, sig_o[3], busy_o[3], done_o[3], exp_sig, vb < 4, vb >= 4);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_min_latency();
        int cyc;
        apply_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        cyc = 0;
        while (done_o[4] !== 1'b1 && cyc < 50) begin
            d_in = CH*W'($urandom);
            step();
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (cyc !== FILL_R + SAMP_R) begin
            failures++;
            $display("FAIL min_latency ur: got %0d cycles want %0d", cyc, FILL_R + SAMP_R);
        end
    endtask

    // One full run on ur with random data, random in_valid density and a stray start pulse
    // mid-run; sig/busy/done/match are compared every cycle against a beat-count model.
    task automatic do_run(input int vpct);
        logic [7:0] exp_sig;
        logic       exp_busy, exp_done, exp_match;
        int         cnt, cyc;
        golden = W'($urandom);
        start = 1'b1;
        in_valid = 1'($urandom);
        d_in = CH*W'($urandom);
        step();
        start = 1'b0;
        exp_sig = SEED_R;
        cnt = 0;
        cyc = 0;
        checks++;
        if ({sig_o[4], busy_o[4], done_o[4], match_o[4]} !== {SEED_R, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL run_start ur: got sig=%h busy=%b done=%b match=%b want %h 1 0 0",
                     sig_o[4], busy_o[4], done_o[4], match_o[4], SEED_R);
        end
        while (cnt < FILL_R + SAMP_R && cyc < 200) begin
            in_valid = ($urandom_range(99) < vpct);
            d_in = CH*W'($urandom);
            start = (cyc == 3);
            step();
            start = 1'b0;
            cyc++;
            if (in_valid) begin
                if (cnt >= FILL_R) exp_sig = misr_ref(exp_sig, merge_ref(d_in));
                cnt++;
            end
            exp_busy  = (cnt < FILL_R + SAMP_R);
            exp_done  = !exp_busy;
            exp_match = CMP && exp_done && (exp_sig == golden);
            checks++;
            if ({sig_o[4], busy_o[4], done_o[4], match_o[4]} !== {exp_sig, exp_busy, exp_done, exp_match}) begin
                failures++;
                $display("FAIL run_cycle%0d ur: got sig=%h busy=%b done=%b match=%b want %h %b %b %b",
                         cyc, sig_o[4], busy_o[4], done_o[4], match_o[4], exp_sig, exp_busy, exp_done, exp_match);
            end
        end
        in_valid = 1'b0;
        if (cyc >= 200) begin
            checks++;
            failures++;
            $display("FAIL run_timeout ur: got no done after %0d cycles want done", cyc);
        end
        golden = exp_sig;
        step();
        checks++;
        if ({sig_o[4], done_o[4], match_o[4]} !== {exp_sig, 1'b1, CMP}) begin
            failures++;
            $display("FAIL run_golden ur: got sig=%h done=%b match=%b want %h 1 %b",
                     sig_o[4], done_o[4], match_o[4], exp_sig, CMP);
        end
    endtask

    task automatic test_random_runs();
        apply_reset();
        do_run(100);
        do_run(60);
        do_run(80);
        do_run(35);
    endtask

    task automatic test_reset_midrun();
        apply_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_in = CH*W'($urandom);
            step();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({sig_o[4], busy_o[4], done_o[4], match_o[4]} !== 11'h0) begin
            failures++;
            $display("FAIL reset_midrun ur: got sig=%h busy=%b done=%b match=%b want all 0",
                     sig_o[4], busy_o[4], done_o[4], match_o[4]);
        end
        @(negedge clk);
        rst = 1'b0;
        do_run(70);
    endtask

    initial begin
        test_reset();
        test_basic_samples();
        test_feedback();
        test_fill();
        test_min_latency();
        test_random_runs();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/channel_signature_unit.md
# channel_signature_unit

Downstream consumer of the three-channel adder/register datapath. It XOR-merges the per-channel result words and compresses a programmed number of them into a MISR signature, so a long run reduces to one comparable word. A small FSM discards the pipeline warm-up beats, counts the sample beats and signals completion. It sits directly after the channel outputs, before the top-level result port.

## Interface
Parameters:
- WIDTH, 32, word width per channel
- CHANNEL, 3, number of channel words on d_in
- SAMPLES, 16, beats compressed per run (≥1)
- FILL, 3, valid beats discarded before compression (≥0)
- POLY, 32'h04C11DB7, MISR feedback polynomial (WIDTH bits)
- SEED, all-ones, signature value loaded on start

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset rst, asynchronous, active-high
- start  in  1  one-cycle run request
- in_valid  in  1  d_in carries a valid beat this cycle
- d_in  in  CHANNEL*WIDTH  channel words; channel k at [k*WIDTH +: WIDTH]
- golden  in  WIDTH  expected signature (used only with compare feature)
- sig  out  WIDTH  current signature
- busy  out  1  high in FILL or RUN
- done  out  1  high in DONE
- match  out  1  sig == golden while in DONE (compare feature only)

## Operation
- merged = XOR of all CHANNEL words of d_in.
- MISR step: t = {sig[WIDTH-2:0],1'b0}; if sig[WIDTH-1] then t ^= POLY; sig_next = t ^ merged.
- States: IDLE, FILL, RUN, DONE.
- IDLE: start → sig←SEED, beat counter←0, go to FILL (or straight to RUN if FILL==0).
- FILL: each in_valid beat increments counter; at the FILL-th beat, counter←0 → RUN. d_in is ignored.
- RUN: each in_valid beat applies one MISR step and increments counter; at the SAMPLES-th beat → DONE. Cycles without in_valid hold all state.
- DONE: sig frozen; start → reload SEED, re-enter FILL/RUN as from IDLE.
- start while in FILL or RUN is ignored.
- Counter width is $clog2(max(FILL,SAMPLES)+1); no wrap within a run.
- Reset values: state IDLE, sig 0, counter 0, busy 0, done 0, match 0.
- rst mid-run aborts immediately: all outputs at reset values, no partial done.

## Timing
- start sampled at edge t: busy high from t+1. sig=SEED visible from t+1.
- Each accepted RUN beat updates sig at that edge; visible the next cycle.
- done rises in the cycle after the edge accepting the final RUN beat; busy falls in the same cycle.
- Minimum run with continuous in_valid: FILL+SAMPLES cycles from busy rising to done rising.
- match is registered; valid from the same cycle as done.

## Configuration
- CSU_GOLDEN_CMP_EN defined: match = registered (sig == golden) in DONE, 0 in every other state; golden is sampled each cycle.
- CSU_GOLDEN_CMP_EN undefined: golden port exists but is unused; match is tied to 0; no comparator logic is built.

## Structure
- Package csu_pkg: state enum (IDLE/FILL/RUN/DONE) and default POLY constant.
- One sub-module, csu_misr_step: combinational, computing sig_next from sig, merged and POLY. The FSM, counter and output registers live in channel_signature_unit.

## Test plan
All scenarios use WIDTH=8, CHANNEL=3, POLY=8'h1D.
- SEED=0, FILL=0, SAMPLES=1: start, then one beat with d_in words 01,02,04 → sig=07, done high in the next cycle, busy low.
- SEED=0, FILL=0, SAMPLES=2: beats merging to 07 then 00 → sig=07 then 0E; done after second beat.
- SEED=80, FILL=0, SAMPLES=1: beat of all-zero words → sig=1D (feedback path).
- FILL=3, SAMPLES=1, in_valid toggling 1/0: first three valid beats have no effect on sig; the fourth valid beat updates sig; idle cycles hold counter and sig.
- rst asserted mid-RUN, then start again → outputs at 0 immediately; next run reproduces the clean-run signature. start pulsed during RUN → no change in sig or counter.
- With CSU_GOLDEN_CMP_EN, golden=0E in the second scenario → match=1 with done; golden=0F → match=0. Without the macro → match stays 0 in both cases.
